otn_frame_rec: RTL and testbench
================================

# otn_frame_rec

Receive-side counterpart of the OTN serial frame sender. It recovers bit timing from the single-wire `i_otn_rx_data` stream and hunts for the OTN frame alignment signal (FAS). Once aligned, it deserializes LSB-first bytes and hands them to the demapper. When ARQ is enabled, it waits for the downstream frame-check verdict and returns a start/ACK/stop sequence on `o_otn_tx_ack`, which the sender uses to decide between completion and retransmission.

## Interface
- `BIT_TICKS`, 20: `i_sclk_en_16_x_baud` pulses per serial bit (TX and RX).
- `SAMPLE_TICK`, 9: phase-counter value at which a data bit is sampled.
- `FRAME_BYTES`, 4164: bytes per frame including the 6 FAS bytes.
- `i_clk`  in  1  single system clock; all logic rising-edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_sclk_en_16_x_baud`  in  1  tick enable, one `i_clk` cycle wide.
- `i_otn_rx_data`  in  1  serial frame data from the sender; asynchronous.
- `o_otn_tx_ack`  out  1  serial ACK to the sender; idles high.
- `o_frame_data`  out  8  received byte.
- `o_frame_data_valid`  out  1  one-cycle strobe qualifying `o_frame_data`.
- `o_frame_data_fas`  out  1  one-cycle pulse when FAS is matched (frame start).
- `o_frame_done`  out  1  one-cycle pulse after the last byte of a frame.
- `i_frame_check_valid`  in  1  downstream verdict strobe.
- `i_frame_check_ok`  in  1  verdict: 1 = frame good, 0 = bad; qualified by `i_frame_check_valid`.
- `i_arq_en`  in  1  ARQ enable switch.

## Operation
- **Input conditioning:** `i_otn_rx_data` passes through a 2-flop synchronizer. Edge detection (XOR of the synced bit with its last value) feeds a phase counter (0..BIT_TICKS-1).
  - The phase counter advances on each tick and wraps at BIT_TICKS-1.
  - Any detected edge forces it to 0, independent of tick.
  - A bit is sampled when tick && phase==SAMPLE_TICK.
- **State machine:** HUNT, DATA, CHECK_WAIT, ACK_START, ACK_BIT, ACK_STOP.
- **HUNT:**
  - Each sampled bit shifts into a 48-bit register from the MSB end (sr <= {bit, sr[47:1]}).
  - Match condition: sr == 48'h28_28_28_F6_F6_F6 (first byte F6 sits in sr[7:0]).
  - On match, pulse `o_frame_data_fas`, clear the bit and byte counters, and go to DATA.
  - FAS bytes are not re-emitted on `o_frame_data`.
- **DATA:**
  - Sampled bits assemble LSB-first into a byte.
  - On the 8th bit, register the byte, pulse valid, and increment the 13-bit byte count.
  - When the count reaches FRAME_BYTES-6 (4158), pulse `o_frame_done`. Then:
    - if `i_arq_en` = 1, go to CHECK_WAIT;
    - otherwise, go to HUNT and clear the shift register.
- **CHECK_WAIT:**
  - The line ignores serial input.
  - On `i_frame_check_valid`, latch `i_frame_check_ok` as the ACK bit and go to ACK_START.
  - Waits indefinitely for the verdict.
- **ACK_START / ACK_BIT / ACK_STOP:** drive `o_otn_tx_ack` to 0, then the latched ACK bit, then 0. Each level lasts exactly BIT_TICKS ticks, timed by a TX tick counter cleared on entry to ACK_START. After ACK_STOP, return `o_otn_tx_ack` to 1 and go to HUNT with the shift register cleared.
- **Ignored verdicts:** `i_frame_check_valid` outside CHECK_WAIT is ignored.
- **`i_arq_en` sampling:** `i_arq_en` is sampled only on the cycle the last byte completes.
- **Sharing:** bit-phase tracking runs in all states; the TX tick counter is used only in the ACK states.

## Timing
- **Reset values:**
  - `o_otn_tx_ack`=1; `o_frame_data`=0; all strobes/pulses=0.
  - State=HUNT; shift register, phase, bit, byte and TX counters=0.
- **Reset mid-operation:** reset in any state (including mid-ACK) drives `o_otn_tx_ack` high on the next cycle and discards any partial byte/frame.
- **Byte latency:** `o_frame_data_valid` asserts the cycle after the sampling cycle of bit 7; data is stable while valid is high.
- **FAS latency:** `o_frame_data_fas` asserts the cycle after the sampling cycle of the 48th FAS bit.
- **Frame-done latency:** `o_frame_done` coincides with the valid strobe of byte FRAME_BYTES-6.
- **Byte rate:** minimum spacing between valid strobes is 8*BIT_TICKS ticks; no backpressure.
- **ACK start:** `o_otn_tx_ack` falls the cycle after `i_frame_check_valid` is accepted. If the verdict arrives on the same cycle the state enters CHECK_WAIT, it is accepted on the next cycle.
- **ACK length:** the sequence spans 3*BIT_TICKS ticks, then the line is held high.
- **Byte counter:** never wraps within a frame; it is cleared in HUNT.

## Test plan
- **FAS lock:** idle line, then FAS bytes F6 F6 F6 28 28 28 plus payload 0x00..0xFF repeating at 20 ticks/bit → one `o_frame_data_fas` pulse, then `o_frame_data` = 0x00, 0x01, …; 4158 valid strobes; `o_frame_done` on the last.
- **False-FAS rejection:** F6 F6 28 28 28 28 followed by noise → no fas pulse, no valid strobes, state remains HUNT.
- **Good ACK:** `i_arq_en`=1, frame then `i_frame_check_valid` with ok=1 → `o_otn_tx_ack` = 0 for 20 ticks, 1 for 20 ticks, 0 for 20 ticks, then 1. ok=0 → pattern 0,0,0 (60 ticks low), then 1.
- **ARQ disabled:** `i_arq_en`=0 → after `o_frame_done`, `o_otn_tx_ack` stays 1; a second back-to-back frame is received fully with a new fas pulse.
- **Phase tolerance:** sender bit period jittered by ±2 ticks with edges on every bit (payload 0x55) → all bytes read 0x55.
- **Mid-ACK reset:** assert `i_rst` during ACK_BIT → `o_otn_tx_ack`=1 next cycle, all outputs at reset values; the next frame is received correctly.

Source files
------------

// File: rtl/otn_frame_rec_if.sv
// OTN receive bundle: recovered bytes toward the demapper
// and the frame-check verdict coming back.
interface otn_frame_rec_if;
  logic [7:0] o_frame_data;
  logic       o_frame_data_valid;
  logic       o_frame_data_fas;
  logic       o_frame_done;
  logic       i_frame_check_valid;
  logic       i_frame_check_ok;

  modport master (
    output o_frame_data,
    output o_frame_data_valid,
    output o_frame_data_fas,
    output o_frame_done,
    input  i_frame_check_valid,
    input  i_frame_check_ok
  );

  modport slave (
    input  o_frame_data,
    input  o_frame_data_valid,
    input  o_frame_data_fas,
    input  o_frame_done,
    output i_frame_check_valid,
    output i_frame_check_ok
  );
endinterface

// File: rtl/otn_frame_rec.sv
// OTN serial frame receiver: bit recovery, FAS hunt, LSB-first
// deserializer and start/ACK/stop reply for ARQ.
module otn_frame_rec #(
  parameter int BIT_TICKS   = 20,
  parameter int SAMPLE_TICK = 9,
  parameter int FRAME_BYTES = 4164
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_sclk_en_16_x_baud,
  input  logic            i_otn_rx_data,
  input  logic            i_arq_en,
  output logic            o_otn_tx_ack,
  otn_frame_rec_if.master dmp
);
  localparam int PW = $clog2(BIT_TICKS);
  localparam logic [PW-1:0] PH_LAST = PW'(BIT_TICKS - 1);
  localparam logic [PW-1:0] PH_SMP  = PW'(SAMPLE_TICK);
  localparam logic [PW-1:0] PH_ONE  = PW'(1);
  localparam logic [12:0]   CNT_END = 13'(FRAME_BYTES - 7);
  localparam logic [47:0]   FAS     = 48'h28_28_28_F6_F6_F6;

  typedef enum logic [2:0] {
    HUNT, DATA, CHECK_WAIT, ACK_START, ACK_BIT, ACK_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    sync_q;
  logic          last_q;
  logic [PW-1:0] phase_q, phase_d;
  logic [PW-1:0] tx_q, tx_d;
  logic [47:0]   sr_q, sr_d;
  logic [7:0]    asm_q, asm_d;
  logic [2:0]    bit_q, bit_d;
  logic [12:0]   cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          ackbit_q, ackbit_d;
  logic          ack_q, ack_d;
  logic          valid_q, valid_d;
  logic          fas_q, fas_d;
  logic          done_q, done_d;
  logic          rx, edge_w, tick, sample;

  assign rx     = sync_q[1];
  assign edge_w = rx ^ last_q;
  assign tick   = i_sclk_en_16_x_baud;
  assign sample = tick && (phase_q == PH_SMP);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    tx_d     = tx_q;
    sr_d     = sr_q;
    asm_d    = asm_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    ackbit_d = ackbit_q;
    valid_d  = 1'b0;
    fas_d    = 1'b0;
    done_d   = 1'b0;
    ack_d    = 1'b1;
    // edges re-center the sample point regardless of tick
    if (edge_w) begin
      phase_d = '0;
    end else if (tick) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_ONE;
    end
    unique case (state_q)
      HUNT: begin
        cnt_d = '0;
        if (sample) begin
          sr_d = {rx, sr_q[47:1]};
          if (sr_d == FAS) begin
            fas_d   = 1'b1;
            bit_d   = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (sample) begin
          asm_d = {rx, asm_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            data_d  = asm_d;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 13'd1;
            if (cnt_q == CNT_END) begin
              done_d = 1'b1;
              if (i_arq_en) begin
                state_d = CHECK_WAIT;
              end else begin
                state_d = HUNT;
                sr_d    = '0;
              end
            end
          end
        end
      end
      CHECK_WAIT: begin
        if (dmp.i_frame_check_valid) begin
          ackbit_d = dmp.i_frame_check_ok;
          tx_d     = '0;
          state_d  = ACK_START;
        end
      end
      ACK_START, ACK_BIT, ACK_STOP: begin
        if (tick) begin
          tx_d = tx_q + PH_ONE;
          if (tx_q == PH_LAST) begin
            tx_d = '0;
            if (state_q == ACK_START) begin
              state_d = ACK_BIT;
            end else if (state_q == ACK_BIT) begin
              state_d = ACK_STOP;
            end else begin
              state_d = HUNT;
              sr_d    = '0;
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase
    case (state_d)
      ACK_START, ACK_STOP: ack_d = 1'b0;
      ACK_BIT:             ack_d = ackbit_d;
      default:             ack_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= HUNT;
      sync_q   <= 2'b11;
      last_q   <= 1'b1;
      phase_q  <= '0;
      tx_q     <= '0;
      sr_q     <= '0;
      asm_q    <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      ackbit_q <= 1'b0;
      ack_q    <= 1'b1;
      valid_q  <= 1'b0;
      fas_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[0], i_otn_rx_data};
      last_q   <= rx;
      phase_q  <= phase_d;
      tx_q     <= tx_d;
      sr_q     <= sr_d;
      asm_q    <= asm_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      ackbit_q <= ackbit_d;
      ack_q    <= ack_d;
      valid_q  <= valid_d;
      fas_q    <= fas_d;
      done_q   <= done_d;
    end
  end

  assign o_otn_tx_ack           = ack_q;
  assign dmp.o_frame_data       = data_q;
  assign dmp.o_frame_data_valid = valid_q;
  assign dmp.o_frame_data_fas   = fas_q;
  assign dmp.o_frame_done       = done_q;
endmodule

// File: tb/tb_otn_frame_rec.sv
// Scoreboard bench for otn_frame_rec: serial sender model,
// expected-byte queue, decoupled output monitor, ACK waveform check.
module tb_otn_frame_rec;
  localparam int BT  = 20;
  localparam int FB  = 16;
  localparam int NPL = FB - 6;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic tick = 1'b0;
  logic rx   = 1'b1;
  logic arq  = 1'b0;
  logic ack;

  otn_frame_rec_if dmp();

  int         vectors  = 0;
  int         errors   = 0;
  int         fas_exp  = 0;
  int         glitches = 0;
  bit         ack_test = 1'b0;
  logic [7:0] exp_q[$];
  bit         exp_done_q[$];
  logic [7:0] pl[$];

  otn_frame_rec #(
    .BIT_TICKS  (BT),
    .SAMPLE_TICK(9),
    .FRAME_BYTES(FB)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_sclk_en_16_x_baud(tick),
    .i_otn_rx_data      (rx),
    .i_arq_en           (arq),
    .o_otn_tx_ack       (ack),
    .dmp                (dmp)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1 tick = ~tick;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // monitor: every strobe is matched against the scoreboard
  always @(negedge clk) begin
    logic [7:0] e;
    bit         d;
    if (dmp.o_frame_data_fas) begin
      vectors++;
      if (fas_exp == 0) begin
        errors++;
        $display("FAIL fas_unexpected got=1 want=0");
      end else begin
        fas_exp--;
      end
    end
    if (dmp.o_frame_data_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL byte_unexpected got=%h want=none",
                 dmp.o_frame_data);
      end else begin
        e = exp_q.pop_front();
        d = exp_done_q.pop_front();
        if (dmp.o_frame_data !== e || dmp.o_frame_done !== d
            || fas_exp != 0) begin
          errors++;
          $display("FAIL byte got=%h done=%b fas_pend=%0d want=%h done=%b fas_pend=0",
                   dmp.o_frame_data, dmp.o_frame_done, fas_exp, e, d);
        end
      end
    end else if (dmp.o_frame_done) begin
      vectors++;
      errors++;
      $display("FAIL done_without_valid got=1 want=0");
    end
    if (!ack && !ack_test) glitches++;
  end

  task automatic check(input string nm, input logic [7:0] got,
                       input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (!tick);
  endtask

  task automatic send_bit(input logic b, input int n);
    #1 rx = b;
    repeat (n) wait_tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit jit);
    for (int i = 0; i < 8; i++) begin
      send_bit(b[i], jit ? int'($urandom_range(BT - 2, BT + 2)) : BT);
    end
  endtask

  // frame = FAS + pl; expectation is queued before transmission
  task automatic send_frame(input bit jit);
    fas_exp++;
    for (int i = 0; i < NPL; i++) begin
      exp_q.push_back(pl[i]);
      exp_done_q.push_back(i == NPL - 1);
    end
    for (int i = 0; i < 3; i++) send_byte(8'hF6, jit);
    for (int i = 0; i < 3; i++) send_byte(8'h28, jit);
    for (int i = 0; i < NPL; i++) send_byte(pl[i], jit);
  endtask

  task automatic fill_random();
    pl.delete();
    for (int i = 0; i < NPL; i++) pl.push_back(8'($urandom));
  endtask

  task automatic verdict(input bit ok);
    @(posedge clk);
    #1;
    dmp.i_frame_check_valid = 1'b1;
    dmp.i_frame_check_ok    = ok;
    @(posedge clk);
    #1 dmp.i_frame_check_valid = 1'b0;
  endtask

  task automatic ack_seq(input bit ok);
    logic want;
    ack_test = 1'b1;
    verdict(ok);
    @(negedge clk);
    check("ack_fall", 8'(ack), 8'h00);
    for (int k = 1; k <= 3 * BT + 1; k++) begin
      while (!tick) @(negedge clk);
      if (k <= BT)          want = 1'b0;
      else if (k <= 2 * BT) want = ok;
      else if (k <= 3 * BT) want = 1'b0;
      else                  want = 1'b1;
      check($sformatf("ack_tick%0d", k), 8'(ack), 8'(want));
      @(negedge clk);
    end
    ack_test = 1'b0;
  endtask

  initial begin
    dmp.i_frame_check_valid = 1'b0;
    dmp.i_frame_check_ok    = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ack", 8'(ack), 8'h01);
    check("rst_data", dmp.o_frame_data, 8'h00);
    check("rst_valid", 8'(dmp.o_frame_data_valid), 8'h00);
    check("rst_fas", 8'(dmp.o_frame_data_fas), 8'h00);
    check("rst_done", 8'(dmp.o_frame_done), 8'h00);

    // stray verdict while hunting must not start an ACK
    repeat (30) send_bit(1'b1, BT);
    verdict(1'b0);
    repeat (40) wait_tick();

    // near-FAS followed by noise
    send_byte(8'hF6, 1'b0);
    send_byte(8'hF6, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'h28, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
    send_bit(1'b1, 4 * BT);

    // two back-to-back frames without ARQ
    arq = 1'b0;
    pl.delete();
    for (int i = 0; i < NPL; i++) pl.push_back(8'(i));
    send_frame(1'b0);
    fill_random();
    send_frame(1'b0);
    send_bit(1'b1, 4 * BT);

    // ARQ good and bad verdicts
    arq = 1'b1;
    fill_random();
    send_frame(1'b0);
    send_bit(1'b1, 2);
    ack_seq(1'b1);
    fill_random();
    send_frame(1'b0);
    send_bit(1'b1, 2);
    ack_seq(1'b0);

    // jittered bit period, alternating bits
    arq = 1'b0;
    pl.delete();
    for (int i = 0; i < NPL; i++) pl.push_back(8'h55);
    send_frame(1'b1);
    send_bit(1'b1, 4 * BT);

    // reset in the middle of ACK_BIT
    arq = 1'b1;
    fill_random();
    send_frame(1'b0);
    send_bit(1'b1, 2);
    ack_test = 1'b1;
    verdict(1'b0);
    repeat (BT + BT / 2) wait_tick();
    @(negedge clk);
    check("midack_low", 8'(ack), 8'h00);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ack", 8'(ack), 8'h01);
    check("midrst_data", dmp.o_frame_data, 8'h00);
    check("midrst_valid", 8'(dmp.o_frame_data_valid), 8'h00);
    check("midrst_done", 8'(dmp.o_frame_done), 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    ack_test = 1'b0;
    arq = 1'b0;
    send_bit(1'b1, 4 * BT);
    fill_random();
    send_frame(1'b0);
    send_bit(1'b1, 20 * BT);

    check("bytes_left", 8'(exp_q.size()), 8'h00);
    check("fas_left", 8'(fas_exp), 8'h00);
    check("ack_glitches", 8'(glitches), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end
endmodule
